// File: rtl/tetris_vram_pkg.sv
// Shared constants and types for the Tetris board VRAM responder and its bench.
package tetris_vram_pkg;
  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;
  localparam int ADDR_W  = 25;
  localparam int DATA_W  = 16;

  localparam logic [DATA_W-1:0] BG_COLOUR = 16'h000F;

  typedef enum logic [1:0] {IDLE, FETCH, LAST} pf_state_e;
endpackage

// File: rtl/tetris_vram_port_sync_fifo.sv
// Single-clock FIFO with flush, occupancy count and a show-ahead head that
// holds the last shown word once the FIFO runs empty.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rptr;
  logic [PW-1:0]    r_wptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_last;
  logic             w_push;
  logic             w_pop;
  logic [PW-1:0]    w_wptr_base;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_full      = (r_count == CW'(DEPTH));
  assign o_empty     = (r_count == '0);
  // A flush empties the FIFO first, so a push in the same cycle always fits.
  assign w_push      = i_push && (i_flush || !o_full);
  assign w_pop       = i_pop && !o_empty && !i_flush;
  assign w_wptr_base = i_flush ? '0 : r_wptr;
  assign o_head      = o_empty ? r_last : r_mem[r_rptr];
  assign o_count     = r_count;

  // NOTE: storage entries are not reset; only pointers and count are, and an entry is never read before it is written.
  always_ff @(posedge clk) begin
    if (reset && w_push) begin
      r_mem[w_wptr_base] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
      r_last  <= '0;
    end else begin
      r_last <= o_head;
      r_wptr <= w_push ? ptr_inc(w_wptr_base) : w_wptr_base;
      if (i_flush) begin
        r_rptr  <= '0;
        r_count <= CW'(w_push);
      end else begin
        if (w_pop) begin
          r_rptr <= ptr_inc(r_rptr);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end
endmodule

// File: rtl/tetris_vram_port.sv
// Board VRAM responder: write FIFO draining into a single-port block RAM and a
// burst prefetcher filling a read FIFO, with writes taking the RAM port first.
module tetris_vram_port
  import tetris_vram_pkg::*;
#(
  parameter int DEPTH    = 256,
  parameter int AW       = 8,
  parameter int BURST    = BOARD_W,
  parameter int WF_DEPTH = 16,
  parameter int RF_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_ld,
  input  logic [ADDR_W-1:0] writeaddr,
  input  logic              write_req,
  input  logic [DATA_W-1:0] writedata,
  output logic [15:0]       wr_buffer,
  input  logic              read_ld,
  input  logic [ADDR_W-1:0] readaddr,
  input  logic              read_req,
  output logic [DATA_W-1:0] readdata,
  output logic [15:0]       rd_buffer,
  output logic              overflow
);
  localparam int WCW = $clog2(WF_DEPTH + 1);
  localparam int RCW = $clog2(RF_DEPTH + 1);
  localparam int RW  = $clog2(BURST + 1);

  logic [DATA_W-1:0] w_wf_head;
  logic [WCW-1:0]    w_wf_count;
  logic              w_wf_full;
  logic              w_wf_empty;
  logic [DATA_W-1:0] w_rf_head;
  logic [RCW-1:0]    w_rf_count;
  logic              w_rf_full;
  logic              w_rf_empty;

  logic [AW-1:0]     r_wptr;
  logic              r_overflow;
  logic              w_drain;
  logic              w_wr_oor;
  logic              w_ram_we;

  pf_state_e         r_state;
  pf_state_e         w_state_nxt;
  logic [ADDR_W-1:0] r_raddr;
  logic [RW-1:0]     r_remaining;
  logic              w_issue;

  logic [DATA_W-1:0] r_ram [DEPTH];
  logic [DATA_W-1:0] r_ram_q;
  logic [AW-1:0]     w_ram_addr;
  logic              r_rd_vld;
  logic              r_rd_oor;
  logic [DATA_W-1:0] w_rd_word;
  logic              w_unused_ok;

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(WF_DEPTH)) u_wr_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_flush (write_ld),
    .i_push  (write_req),
    .i_data  (writedata),
    .i_pop   (w_drain),
    .o_head  (w_wf_head),
    .o_count (w_wf_count),
    .o_full  (w_wf_full),
    .o_empty (w_wf_empty)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(RF_DEPTH)) u_rd_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_flush (read_ld),
    .i_push  (r_rd_vld && !read_ld),
    .i_data  (w_rd_word),
    .i_pop   (read_req),
    .o_head  (w_rf_head),
    .o_count (w_rf_count),
    .o_full  (w_rf_full),
    .o_empty (w_rf_empty)
  );

  // The drain beats prefetch issue, but a read_ld cycle reserves the RAM port
  // for the read restart; a write_ld discards whatever is still queued.
  assign w_drain  = !w_wf_empty && !write_ld && !read_ld;
  assign w_wr_oor = (32'(r_wptr) >= 32'(DEPTH));
  assign w_ram_we = w_drain && !w_wr_oor && reset;
  assign w_issue  = (r_state == FETCH) && !w_drain && !read_ld;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (write_ld) begin
        r_wptr <= writeaddr[AW-1:0];
      end else if (w_drain) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (write_req && w_wf_full && !write_ld) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    if (read_ld) begin
      w_state_nxt = FETCH;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = IDLE;
        FETCH:   if (w_issue && r_remaining == RW'(1)) w_state_nxt = LAST;
        LAST:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_raddr     <= '0;
      r_remaining <= '0;
      r_rd_vld    <= 1'b0;
      r_rd_oor    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rd_vld <= w_issue;
      r_rd_oor <= (32'(r_raddr) >= 32'(DEPTH));
      if (read_ld) begin
        r_raddr     <= readaddr;
        r_remaining <= RW'(BURST);
      end else if (w_issue) begin
        r_raddr     <= r_raddr + ADDR_W'(1);
        r_remaining <= r_remaining - RW'(1);
      end
    end
  end

  assign w_ram_addr = w_drain ? r_wptr : r_raddr[AW-1:0];

  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_ram[w_ram_addr] <= w_wf_head;
    end else if (w_issue) begin
      r_ram_q <= r_ram[w_ram_addr];
    end
  end

  assign w_rd_word   = r_rd_oor ? '0 : r_ram_q;
  assign wr_buffer   = 16'(w_wf_count);
  assign rd_buffer   = 16'(w_rf_count);
  assign readdata    = w_rf_head;
  assign overflow    = r_overflow;
  assign w_unused_ok = &{1'b0, writeaddr[ADDR_W-1:AW], w_rf_full, w_rf_empty};
endmodule

// File: tb/tb_tetris_vram_port.sv
// Directed bench for tetris_vram_port: write latency, board fill and sweep,
// burst timing and ordering, overflow, read restart and mid-burst reset.
module tb_tetris_vram_port;
  import tetris_vram_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        write_ld = 1'b0;
  logic [24:0] writeaddr = '0;
  logic        write_req = 1'b0;
  logic [15:0] writedata = '0;
  logic [15:0] wr_buffer;
  logic        read_ld = 1'b0;
  logic [24:0] readaddr = '0;
  logic        read_req = 1'b0;
  logic [15:0] readdata;
  logic [15:0] rd_buffer;
  logic        overflow;

  int checks = 0;
  int failures = 0;

  tetris_vram_port dut (
    .clk       (clk),
    .reset     (reset),
    .write_ld  (write_ld),
    .writeaddr (writeaddr),
    .write_req (write_req),
    .writedata (writedata),
    .wr_buffer (wr_buffer),
    .read_ld   (read_ld),
    .readaddr  (readaddr),
    .read_req  (read_req),
    .readdata  (readdata),
    .rd_buffer (rd_buffer),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld_write(input logic [24:0] a);
    writeaddr = a; write_ld = 1'b1; tick(); write_ld = 1'b0;
  endtask

  task automatic push(input logic [15:0] d);
    writedata = d; write_req = 1'b1; tick(); write_req = 1'b0;
  endtask

  task automatic ld_read(input logic [24:0] a);
    readaddr = a; read_ld = 1'b1; tick(); read_ld = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    checks++; if (wr_buffer !== 16'd0) begin failures++; $display("FAIL reset_wr_buffer: got %0d expected 0", wr_buffer); end
    checks++; if (rd_buffer !== 16'd0) begin failures++; $display("FAIL reset_rd_buffer: got %0d expected 0", rd_buffer); end
    checks++; if (readdata !== 16'h0000) begin failures++; $display("FAIL reset_readdata: got %h expected 0000", readdata); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic_write();
    ld_write(25'd5);
    push(16'hABCD);
    checks++; if (wr_buffer !== 16'd1) begin failures++; $display("FAIL push_latency_t1: got %0d expected 1", wr_buffer); end
    tick();
    checks++; if (wr_buffer !== 16'd0) begin failures++; $display("FAIL push_latency_t2: got %0d expected 0", wr_buffer); end
    // load and push together: the word lands at the new address
    writeaddr = 25'd8; write_ld = 1'b1; writedata = 16'h1234; write_req = 1'b1;
    tick();
    write_ld = 1'b0; write_req = 1'b0;
    checks++; if (wr_buffer !== 16'd1) begin failures++; $display("FAIL ld_and_push: got %0d expected 1", wr_buffer); end
    tick();
    ld_read(25'd0);
    repeat (11) tick();
    checks++; if (rd_buffer !== 16'd10) begin failures++; $display("FAIL basic_burst_count: got %0d expected 10", rd_buffer); end
    read_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        checks++; if (readdata !== 16'hABCD) begin failures++; $display("FAIL basic_word5: got %h expected abcd", readdata); end
      end
      if (i == 8) begin
        checks++; if (readdata !== 16'h1234) begin failures++; $display("FAIL basic_word8: got %h expected 1234", readdata); end
      end
      tick();
    end
    read_req = 1'b0;
  endtask

  task automatic test_fill_sweep();
    int n;
    ld_write(25'd0);
    for (int i = 0; i < BOARD_W * BOARD_H; i++) begin
      push(BG_COLOUR);
      n = 0;
      while (wr_buffer !== 16'd0 && n < 8) begin tick(); n++; end
      checks++; if (wr_buffer !== 16'd0) begin failures++; $display("FAIL fill_pace %0d: got %0d expected 0", i, wr_buffer); end
    end
    for (int r = 0; r < BOARD_H; r++) begin
      ld_read(25'(r * BOARD_W));
      repeat (11) tick();
      checks++; if (rd_buffer !== 16'd10) begin failures++; $display("FAIL sweep_count row %0d: got %0d expected 10", r, rd_buffer); end
      read_req = 1'b1;
      for (int i = 0; i < BOARD_W; i++) begin
        checks++; if (readdata !== BG_COLOUR) begin failures++; $display("FAIL sweep_word row %0d col %0d: got %h expected %h", r, i, readdata, BG_COLOUR); end
        tick();
      end
      read_req = 1'b0;
      checks++; if (rd_buffer !== 16'd0) begin failures++; $display("FAIL sweep_empty row %0d: got %0d expected 0", r, rd_buffer); end
    end
  endtask

  task automatic test_row_burst();
    ld_write(25'd30);
    for (int i = 0; i < 10; i++) push(16'h0100 + 16'(i));
    tick();
    checks++; if (wr_buffer !== 16'd0) begin failures++; $display("FAIL row3_preload: got %0d expected 0", wr_buffer); end
    ld_read(25'd30);
    tick(); tick();
    checks++; if (rd_buffer !== 16'd1) begin failures++; $display("FAIL burst_first_t3: got %0d expected 1", rd_buffer); end
    repeat (8) tick();
    checks++; if (rd_buffer !== 16'd9) begin failures++; $display("FAIL burst_t11: got %0d expected 9", rd_buffer); end
    tick();
    checks++; if (rd_buffer !== 16'd10) begin failures++; $display("FAIL burst_full_t12: got %0d expected 10", rd_buffer); end
    read_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++; if (readdata !== 16'h0100 + 16'(i)) begin failures++; $display("FAIL row3_word %0d: got %h expected %h", i, readdata, 16'h0100 + 16'(i)); end
      tick();
    end
    checks++; if (rd_buffer !== 16'd0) begin failures++; $display("FAIL row3_drained: got %0d expected 0", rd_buffer); end
    checks++; if (readdata !== 16'h0109) begin failures++; $display("FAIL row3_hold: got %h expected 0109", readdata); end
    tick();
    checks++; if (readdata !== 16'h0109) begin failures++; $display("FAIL pop_empty_hold: got %h expected 0109", readdata); end
    checks++; if (rd_buffer !== 16'd0) begin failures++; $display("FAIL pop_empty_count: got %0d expected 0", rd_buffer); end
    read_req = 1'b0;
  endtask

  task automatic test_overflow();
    int n;
    ld_write(25'd100);
    readaddr = 25'd0; read_ld = 1'b1; write_req = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      writedata = 16'hE000 + 16'(k - 1);
      tick();
      if (k <= 16) begin
        checks++; if (wr_buffer !== 16'(k)) begin failures++; $display("FAIL ovf_fill %0d: got %0d expected %0d", k, wr_buffer, k); end
      end
      if (k == 16) begin
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early: got %b expected 0", overflow); end
      end
    end
    checks++; if (wr_buffer !== 16'd16) begin failures++; $display("FAIL ovf_saturate: got %0d expected 16", wr_buffer); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    read_ld = 1'b0; write_req = 1'b0;
    n = 0;
    while (rd_buffer !== 16'd10 && n < 64) begin tick(); n++; end
    checks++; if (rd_buffer !== 16'd10) begin failures++; $display("FAIL stalled_burst_count: got %0d expected 10", rd_buffer); end
    checks++; if (wr_buffer !== 16'd0) begin failures++; $display("FAIL ovf_drained: got %0d expected 0", wr_buffer); end
    read_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++; if (readdata !== BG_COLOUR) begin failures++; $display("FAIL stalled_burst_word %0d: got %h expected %h", i, readdata, BG_COLOUR); end
      tick();
    end
    read_req = 1'b0;
    ld_read(25'd106);
    repeat (11) tick();
    read_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++; if (readdata !== 16'hE006 + 16'(i)) begin failures++; $display("FAIL ovf_word %0d: got %h expected %h", i, readdata, 16'hE006 + 16'(i)); end
      tick();
    end
    read_req = 1'b0;
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_restart();
    ld_write(25'd50);
    for (int i = 0; i < 10; i++) push(16'h0500 + 16'(i));
    tick();
    ld_read(25'd0);
    repeat (4) tick();
    checks++; if (rd_buffer !== 16'd3) begin failures++; $display("FAIL restart_partial: got %0d expected 3", rd_buffer); end
    ld_read(25'd50);
    checks++; if (rd_buffer !== 16'd0) begin failures++; $display("FAIL restart_flush: got %0d expected 0", rd_buffer); end
    repeat (11) tick();
    checks++; if (rd_buffer !== 16'd10) begin failures++; $display("FAIL restart_count: got %0d expected 10", rd_buffer); end
    tick();
    checks++; if (rd_buffer !== 16'd10) begin failures++; $display("FAIL restart_settled: got %0d expected 10", rd_buffer); end
    read_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++; if (readdata !== 16'h0500 + 16'(i)) begin failures++; $display("FAIL restart_word %0d: got %h expected %h", i, readdata, 16'h0500 + 16'(i)); end
      tick();
    end
    read_req = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    ld_read(25'd30);
    repeat (4) tick();
    // a write presented during reset must not reach the RAM
    reset = 1'b0;
    writeaddr = 25'd60; write_ld = 1'b1; writedata = 16'hDEAD; write_req = 1'b1;
    tick();
    reset = 1'b1; write_ld = 1'b0; write_req = 1'b0;
    checks++; if (wr_buffer !== 16'd0) begin failures++; $display("FAIL midrst_wr_buffer: got %0d expected 0", wr_buffer); end
    checks++; if (rd_buffer !== 16'd0) begin failures++; $display("FAIL midrst_rd_buffer: got %0d expected 0", rd_buffer); end
    checks++; if (readdata !== 16'h0000) begin failures++; $display("FAIL midrst_readdata: got %h expected 0000", readdata); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL midrst_overflow: got %b expected 0", overflow); end
    repeat (3) tick();
    checks++; if (rd_buffer !== 16'd0) begin failures++; $display("FAIL midrst_quiet: got %0d expected 0", rd_buffer); end
    ld_read(25'd30);
    repeat (11) tick();
    checks++; if (rd_buffer !== 16'd10) begin failures++; $display("FAIL postrst_count: got %0d expected 10", rd_buffer); end
    read_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++; if (readdata !== 16'h0100 + 16'(i)) begin failures++; $display("FAIL postrst_word %0d: got %h expected %h", i, readdata, 16'h0100 + 16'(i)); end
      tick();
    end
    read_req = 1'b0;
    ld_read(25'd60);
    repeat (11) tick();
    read_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++; if (readdata !== BG_COLOUR) begin failures++; $display("FAIL postrst_row6 %0d: got %h expected %h", i, readdata, BG_COLOUR); end
      tick();
    end
    read_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_fill_sweep();
    test_row_burst();
    test_overflow();
    test_restart();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tetris_vram_port.md
Name: tetris_vram_port

Overview:
- Responder side of the board-VRAM FIFO protocol used by the Tetris draw and row-copy engine.
- Accepts address loads, write pushes and burst read requests, and backs them with on-chip block RAM holding the 10x20 board, one 16-bit colour word per cell.
- Sits between the tetris engine and the colour mapper. It stands in for the SDRAM FIFO controller in simulation and in builds without SDRAM.

Parameters:
- DEPTH, 256: RAM words; addresses >= DEPTH are out of range.
- AW, 8: RAM address bits taken from the low end of the 25-bit addresses.
- BURST, 10: words prefetched per read_ld (one board row).
- WF_DEPTH, 16: write FIFO entries.
- RF_DEPTH, 16: read FIFO entries; must be >= BURST.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- write_ld  in  1  one-cycle pulse; loads writeaddr and flushes the write FIFO.
- writeaddr  in  25  start address for subsequent writes.
- write_req  in  1  one-cycle pulse; pushes writedata.
- writedata  in  16  word to write.
- wr_buffer  out  16  words pending in the write FIFO.
- read_ld  in  1  one-cycle pulse; flushes the read FIFO and starts a BURST prefetch from readaddr.
- readaddr  in  25  burst start address.
- read_req  in  1  level; pops one word per cycle while rd_buffer != 0.
- readdata  out  16  head of the read FIFO (show-ahead).
- rd_buffer  out  16  words available in the read FIFO.
- overflow  out  1  sticky; a write_req was dropped because the write FIFO was full.

Behaviour:
- Reset (reset==0 at a clk edge):
  - wr_buffer=0, rd_buffer=0, readdata=0, overflow=0.
  - Both FIFOs empty, write pointer 0, prefetch idle.
  - RAM contents are not cleared.
  - Reset asserted mid-burst or mid-drain aborts the operation with no partial RAM write after the reset edge.
- Write path:
  - write_ld at cycle t: wptr<=writeaddr[AW-1:0], write FIFO flushed, wr_buffer=0 at t+1.
  - write_req at t pushes; wr_buffer increments at t+1.
  - Drain: when the FIFO is non-empty and the RAM port is granted, the head is written to RAM[wptr], wptr increments (wraps at 2^AW), and wr_buffer decrements on the same edge.
  - Minimum push-to-RAM latency is 2 cycles, so wr_buffer returns to 0 at t+2 for an isolated push.
  - Simultaneous write_ld and write_req: the load takes effect first, then the data is pushed for the new address.
  - Push with the FIFO full: the word is dropped, overflow<=1, wr_buffer unchanged.
  - Out-of-range wptr: the drain pops the word but suppresses the RAM write.
- Read path:
  - The prefetch FSM has three states:
    - IDLE: on read_ld, latch raddr and set remaining=BURST, then go to FETCH.
    - FETCH: issue RAM read at raddr when granted, raddr+1, remaining-1; when remaining hits 0 go to LAST.
    - LAST: wait one cycle for the final RAM data, then go to IDLE.
  - RAM read latency is 1 cycle. Data enters the read FIFO the cycle after issue; out-of-range addresses return 0.
  - With no competing writes, read_ld at t gives rd_buffer=1 at t+3 and rd_buffer=BURST at t+12.
  - Pop: read_req && rd_buffer!=0 advances the head; readdata shows the next word from the following cycle.
  - read_req with the FIFO empty is ignored; readdata holds its last value.
  - rd_buffer reflects push and pop in the same cycle as a net change.
  - read_ld in any state aborts the current prefetch, discards in-flight data, flushes the FIFO and restarts. A pop in the same cycle is ignored.
- Arbitration:
  - Single-port RAM; write drain has priority over prefetch issue.
  - A stalled prefetch retries each cycle with no lost or duplicated addresses.
  - A read issued after a drain to the same address returns the new data.
- Widths: wr_buffer and rd_buffer are zero-extended counts, never above WF_DEPTH or RF_DEPTH.

Decomposition:
- Package tetris_vram_pkg holds:
  - BOARD_W=10, BOARD_H=20, ADDR_W=25, DATA_W=16.
  - Background colour constant 16'h000F.
  - Prefetch state enum {IDLE, FETCH, LAST}.
- Sub-module sync_fifo (parameterised width and depth, with flush, count, show-ahead head), instantiated twice: write FIFO and read FIFO.
- RAM is an inferred array inside tetris_vram_port.

Test Plan:
- Reset, then write_ld addr 5 and write_req 16'hABCD -> wr_buffer=1 next cycle, 0 two cycles later. Burst read from 0 returns word 5 = ABCD.
- write_ld 0, then 200 pushes of 16'h000F paced on wr_buffer==0 -> a 20 row x 10 word burst read sweep returns all 000F.
- Preload row 3 (addresses 30-39) with 0x0100+i; read_ld 30 -> rd_buffer=10 at t+12. Holding read_req yields 0100..0109 in order, then rd_buffer=0 and readdata stays 0109.
- 17 back-to-back write_req while read_ld holds the RAM busy -> FIFO saturates at 16, 17th dropped, overflow=1.
- read_ld 0, then read_ld 50 mid-burst -> FIFO contains only words 50-59 and rd_buffer ends at 10.
- Start a 10-word burst, pull reset low for one cycle at burst word 4 -> all outputs 0. A following read_ld behaves normally and RAM data is intact.
